lsu_mem_stage: RTL and testbench



---
 rtl/riscv_pkg.sv | 35 +++
 rtl/load_extend.sv | 41 ++++
 rtl/lsu_mem_stage.sv | 192 +++++++++++++++++++
 tb/tb_lsu_mem_stage.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_pkg
//  Brief    : Shared load/store encodings, LSU state encoding, byte enables
//  Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    // funct3 encodings for loads and stores (instruction bits [14:12])
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // LSU state encoding
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_REQ  = 2'b01;
    localparam logic [1:0] ST_WAIT = 2'b10;
    localparam logic [1:0] ST_DONE = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_REQ  = ST_REQ,
        S_WAIT = ST_WAIT,
        S_DONE = ST_DONE
    } lsu_state_t;

    // Byte-enable base patterns, shifted into place by the address offset
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

endpackage
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// ============================================================================
//  Module   : load_extend
//  Brief    : Selects the byte/half/word lane of a read word and sign- or
//             zero-extends it to 32 bits according to funct3
//  Revision : 1.0 - initial release
// ============================================================================
module load_extend
    import riscv_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection followed by extension; unknown funct3 passes the word through
    always_comb begin
        byte_sel = word[7:0];
        case (offset)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = offset[1] ? word[31:16] : word[15:0];

        case (funct3)
            F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   result = {24'h000000, byte_sel};
            F3_H:    result = {{16{half_sel[15]}}, half_sel};
            F3_HU:   result = {16'h0000, half_sel};
            default: result = word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_mem_stage
//  Brief    : Load/store stage: decodes faults, issues a valid/ready data
//             memory request, stalls the core until the response returns and
//             hands extended load data to writeback
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_stage
    import riscv_pkg::*;
#(
    parameter int TIMEOUT = 255
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        illegal,
    output logic        bus_err,
    output logic        req_valid,
    input  logic        req_ready,
    output logic        req_we,
    output logic [31:0] req_addr,
    output logic [3:0]  req_be,
    output logic [31:0] req_wdata,
    input  logic        resp_valid,
    input  logic [31:0] resp_rdata
);

    // Counter only needs to reach TIMEOUT-1; a zero TIMEOUT never expires
    localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    lsu_state_t        state;
    lsu_state_t        state_next;
    logic [CNT_W-1:0]  tmo_cnt;
    logic [2:0]        lat_funct3;
    logic [1:0]        lat_offset;
    logic              access;
    logic              go;
    logic              tmo_hit;
    logic              launch;
    logic              handshake;
    logic              capture;
    logic              expire;
    logic [3:0]        be_next;
    logic [31:0]       wdata_next;
    logic [31:0]       ext_data;

    assign access = mem_read | mem_write;

    // Fault decode is purely combinational so the core can trap in the same cycle
    assign misaligned = access &
                        ((((funct3 == F3_H) | (funct3 == F3_HU)) & addr[0]) |
                         ((funct3 == F3_W) & (addr[1:0] != 2'b00)));
    assign illegal    = access &
                        ((funct3 == 3'b011) | (funct3 == 3'b110) | (funct3 == 3'b111) |
                         (mem_write & funct3[2]));
    assign go         = access & ~misaligned & ~illegal;
    assign tmo_hit    = (TIMEOUT != 0) && (tmo_cnt == CNT_LAST);

    // Store lane steering: replicate data so any selected lane carries it
    always_comb begin
        be_next    = BE_WORD;
        wdata_next = '0;
        if (mem_write) begin
            case (funct3)
                F3_B: begin
                    be_next    = BE_BYTE << addr[1:0];
                    wdata_next = {4{store_data[7:0]}};
                end
                F3_H: begin
                    be_next    = BE_HALF << {addr[1], 1'b0};
                    wdata_next = {2{store_data[15:0]}};
                end
                default: begin
                    be_next    = BE_WORD;
                    wdata_next = store_data;
                end
            endcase
        end
    end

    // Extraction uses the offset/funct3 latched at launch, not the live inputs
    load_extend u_load_extend (
        .word   (resp_rdata),
        .offset (lat_offset),
        .funct3 (lat_funct3),
        .result (ext_data)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control strobes; DONE always returns to IDLE so the
    // still-presented instruction is not launched a second time
    always_comb begin
        state_next = state;
        launch     = 1'b0;
        handshake  = 1'b0;
        capture    = 1'b0;
        expire     = 1'b0;
        stall      = 1'b0;
        case (state)
            S_IDLE: begin
                if (go) begin
                    launch     = 1'b1;
                    stall      = 1'b1;
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                stall = 1'b1;
                if (req_ready) begin
                    handshake  = 1'b1;
                    state_next = S_WAIT;
                end else if (tmo_hit) begin
                    expire     = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                if (resp_valid) begin
                    capture    = 1'b1;
                    state_next = S_DONE;
                end else if (tmo_hit) begin
                    expire     = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Request registers, timeout counter and load result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_valid  <= 1'b0;
            req_we     <= 1'b0;
            req_addr   <= '0;
            req_be     <= '0;
            req_wdata  <= '0;
            lat_funct3 <= '0;
            lat_offset <= '0;
            tmo_cnt    <= '0;
            bus_err    <= 1'b0;
            load_data  <= '0;
        end else begin
            bus_err <= expire;
            if (launch) begin
                req_valid  <= 1'b1;
                req_we     <= mem_write;
                req_addr   <= {addr[31:2], 2'b00};
                req_be     <= be_next;
                req_wdata  <= wdata_next;
                lat_funct3 <= funct3;
                lat_offset <= addr[1:0];
                tmo_cnt    <= '0;
            end else if (handshake) begin
                req_valid <= 1'b0;
                tmo_cnt   <= '0;
            end else if (expire) begin
                req_valid <= 1'b0;
            end else if ((state == S_REQ || state == S_WAIT) && (TIMEOUT != 0)) begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
            if (capture && !req_we) begin
                load_data <= ext_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_lsu_mem_stage
//  Brief    : Self-checking bench for lsu_mem_stage with a behavioural model
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0;
    logic [31:0] store_data = '0;
    logic        req_ready = 1'b0;
    logic        resp_valid = 1'b0;
    logic [31:0] resp_rdata = '0;
    logic        req_ready_t = 1'b0;
    logic        resp_valid_t = 1'b0;

    logic        stall, misaligned, illegal, bus_err, req_valid, req_we;
    logic [31:0] load_data, req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        stall_t, misaligned_t, illegal_t, bus_err_t, req_valid_t, req_we_t;
    logic [31:0] load_data_t, req_addr_t, req_wdata_t;
    logic [3:0]  req_be_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_ld = '0;
    logic [31:0] obs_addr, obs_wdata;
    logic [3:0]  obs_be;
    int          obs_stall;

    always #5 clk = ~clk;

    lsu_mem_stage dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .store_data(store_data),
        .stall(stall), .load_data(load_data), .misaligned(misaligned),
        .illegal(illegal), .bus_err(bus_err), .req_valid(req_valid),
        .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
        .req_be(req_be), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata)
    );

    lsu_mem_stage #(.TIMEOUT(4)) dut_to (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .store_data(store_data),
        .stall(stall_t), .load_data(load_data_t), .misaligned(misaligned_t),
        .illegal(illegal_t), .bus_err(bus_err_t), .req_valid(req_valid_t),
        .req_ready(req_ready_t), .req_we(req_we_t), .req_addr(req_addr_t),
        .req_be(req_be_t), .req_wdata(req_wdata_t), .resp_valid(resp_valid_t),
        .resp_rdata(resp_rdata)
    );

    // ---------------- reference model ----------------
    function automatic int acc_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] off,
                                             input logic [2:0] f3);
        logic [31:0] sh;
        sh = w >> (8 * off);
        case (f3)
            3'b000:  return 32'($signed(sh[7:0]));
            3'b001:  return 32'($signed(sh[15:0]));
            3'b100:  return {24'd0, sh[7:0]};
            3'b101:  return {16'd0, sh[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic void ref_fault(input bit ld, input logic [2:0] f3, input logic [1:0] off,
                                      output bit mis, output bit ill);
        bit legal;
        legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        ill   = !legal || (!ld && f3[2]);
        mis   = legal && ((int'(off) % acc_size(f3)) != 0);
    endfunction

    function automatic logic [3:0] ref_be(input bit ld, input logic [2:0] f3, input logic [1:0] off);
        if (ld) return 4'hF;
        return 4'(((1 << acc_size(f3)) - 1) << off);
    endfunction

    function automatic logic [31:0] ref_wdata(input bit ld, input logic [2:0] f3, input logic [31:0] d);
        if (ld) return 32'd0;
        case (acc_size(f3))
            1:       return {4{d[7:0]}};
            2:       return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        mem_read = 0; mem_write = 0; req_ready = 0; resp_valid = 0;
        req_ready_t = 0; resp_valid_t = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        exp_ld = '0;
        #1;
    endtask

    // One complete access; rd = REQ cycles with req_ready low, pd = WAIT cycles before resp
    task automatic run_txn(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] sd, input int rd, input int pd,
                           input logic [31:0] rdata, input string tag);
        bit mis, ill;
        logic [3:0]  ebe;
        logic [31:0] ewd, eaddr;
        int nst;
        ref_fault(ld, f3, a[1:0], mis, ill);
        ebe = ref_be(ld, f3, a[1:0]);
        ewd = ref_wdata(ld, f3, sd);
        eaddr = a & 32'hFFFF_FFFC;
        mem_read = ld; mem_write = !ld; funct3 = f3; addr = a; store_data = sd;
        #1;
        checks++;
        if (misaligned !== mis || illegal !== ill) begin
            errors++;
            $display("FAIL %s fault: got mis=%b ill=%b expected mis=%b ill=%b", tag, misaligned, illegal, mis, ill);
        end
        if (mis || ill) begin
            for (int c = 0; c < 2; c++) begin
                checks++;
                if (stall !== 1'b0 || req_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s fault_idle: got stall=%b req_valid=%b expected 0 0", tag, stall, req_valid);
                end
                @(posedge clk); #1;
            end
            mem_read = 0; mem_write = 0;
            obs_stall = 0;
            return;
        end
        nst = 0;
        checks++;
        if (stall !== 1'b1 || req_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s launch: got stall=%b req_valid=%b expected 1 0", tag, stall, req_valid);
        end
        if (stall) nst++;
        @(posedge clk); #1;
        for (int k = 0; k <= rd; k++) begin
            resp_valid = ($urandom_range(0, 3) == 0);
            resp_rdata = $urandom;
            checks++;
            if (req_valid !== 1'b1 || req_we !== !ld || req_addr !== eaddr || req_be !== ebe ||
                req_wdata !== ewd || stall !== 1'b1) begin
                errors++;
                $display("FAIL %s req[%0d]: got v=%b we=%b a=%h be=%b wd=%h st=%b expected 1 %b %h %b %h 1",
                         tag, k, req_valid, req_we, req_addr, req_be, req_wdata, stall, !ld, eaddr, ebe, ewd);
            end
            if (k == 0) begin
                obs_addr = req_addr; obs_be = req_be; obs_wdata = req_wdata;
            end
            if (stall) nst++;
            if (k == rd) req_ready = 1;
            @(posedge clk); #1;
            req_ready = 0;
        end
        resp_valid = 0;
        for (int j = 0; j <= pd; j++) begin
            checks++;
            if (req_valid !== 1'b0 || stall !== 1'b1 || load_data !== exp_ld) begin
                errors++;
                $display("FAIL %s wait[%0d]: got v=%b st=%b ld=%h expected 0 1 %h", tag, j, req_valid, stall, load_data, exp_ld);
            end
            if (stall) nst++;
            resp_valid = (j == pd);
            resp_rdata = (j == pd) ? rdata : $urandom;
            @(posedge clk); #1;
        end
        resp_valid = 0;
        if (ld) exp_ld = ref_load(rdata, a[1:0], f3);
        checks++;
        if (stall !== 1'b0 || bus_err !== 1'b0 || load_data !== exp_ld) begin
            errors++;
            $display("FAIL %s done: got st=%b be=%b ld=%h expected 0 0 %h", tag, stall, bus_err, load_data, exp_ld);
        end
        obs_stall = nst;
        @(posedge clk); #1;
        mem_read = 0; mem_write = 0;
        #1;
        checks++;
        if (stall !== 1'b0 || req_valid !== 1'b0 || load_data !== exp_ld) begin
            errors++;
            $display("FAIL %s after_done: got st=%b v=%b ld=%h expected 0 0 %h", tag, stall, req_valid, load_data, exp_ld);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++;
        if (stall !== 0 || req_valid !== 0 || req_we !== 0 || req_be !== 4'h0 || bus_err !== 0) begin
            errors++;
            $display("FAIL reset_ctrl: got st=%b v=%b we=%b be=%b berr=%b expected all 0", stall, req_valid, req_we, req_be, bus_err);
        end
        checks++;
        if (req_addr !== 32'd0 || req_wdata !== 32'd0 || load_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_data: got a=%h wd=%h ld=%h expected 0", req_addr, req_wdata, load_data);
        end
    endtask

    task automatic test_store_byte();
        run_txn(1'b0, 3'b000, 32'h0000_1003, 32'hAABB_CCDD, 0, 0, 32'h0, "sb");
        checks++;
        if (obs_addr !== 32'h0000_1000 || obs_be !== 4'b1000 || obs_wdata !== 32'hDDDD_DDDD) begin
            errors++;
            $display("FAIL sb_fields: got a=%h be=%b wd=%h expected 00001000 1000 dddddddd", obs_addr, obs_be, obs_wdata);
        end
        checks++;
        if (obs_stall !== 3) begin
            errors++;
            $display("FAIL sb_stall_len: got %0d expected 3", obs_stall);
        end
    endtask

    task automatic test_load_extend();
        run_txn(1'b1, 3'b000, 32'h0000_2002, 32'h0, 0, 0, 32'h0080_FF11, "lb");
        checks++;
        if (load_data !== 32'hFFFF_FF80) begin
            errors++;
            $display("FAIL lb_value: got %h expected ffffff80", load_data);
        end
        run_txn(1'b1, 3'b100, 32'h0000_2002, 32'h0, 0, 0, 32'h0080_FF11, "lbu");
        checks++;
        if (load_data !== 32'h0000_0080) begin
            errors++;
            $display("FAIL lbu_value: got %h expected 00000080", load_data);
        end
    endtask

    task automatic test_misaligned();
        mem_read = 1; mem_write = 0; funct3 = 3'b001; addr = 32'h0000_2001;
        #1;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (misaligned !== 1'b1 || illegal !== 1'b0 || stall !== 1'b0 || req_valid !== 1'b0) begin
                errors++;
                $display("FAIL lh_misaligned[%0d]: got mis=%b ill=%b st=%b v=%b expected 1 0 0 0", c, misaligned, illegal, stall, req_valid);
            end
            @(posedge clk); #1;
        end
        mem_read = 0;
    endtask

    task automatic test_ready_hold();
        run_txn(1'b1, 3'b010, 32'h0000_5004, 32'h0, 10, 0, 32'h1234_5678, "lw_hold");
        checks++;
        if (load_data !== 32'h1234_5678 || obs_stall !== 13) begin
            errors++;
            $display("FAIL lw_hold_result: got ld=%h stall_cycles=%0d expected 12345678 13", load_data, obs_stall);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] legal [5];
        bit ld;
        logic [2:0] f3;
        legal = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int i = 0; i < 40; i++) begin
            ld = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
            else                           f3 = legal[$urandom_range(0, 4)];
            run_txn(ld, f3, $urandom, $urandom, $urandom_range(0, 4), $urandom_range(0, 4),
                    $urandom, "rand");
        end
    endtask

    task automatic test_reset_mid();
        run_txn(1'b1, 3'b010, 32'h0000_6000, 32'h0, 0, 0, 32'h5555_AAAA, "pre_rst");
        mem_read = 1; mem_write = 0; funct3 = 3'b010; addr = 32'h0000_3000;
        @(posedge clk); #1;
        req_ready = 1;
        @(posedge clk); #1;
        req_ready = 0;
        checks++;
        if (stall !== 1'b1 || req_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_wait: got st=%b v=%b expected 1 0", stall, req_valid);
        end
        #2;
        mem_read = 0;
        rst_n = 0;
        #1;
        checks++;
        if (stall !== 1'b0 || req_valid !== 1'b0 || load_data !== 32'd0 || req_addr !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid_async: got st=%b v=%b ld=%h a=%h expected 0 0 0 0", stall, req_valid, load_data, req_addr);
        end
        @(posedge clk); #1;
        rst_n = 1;
        resp_valid = 1; resp_rdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        resp_valid = 0;
        @(posedge clk); #1;
        checks++;
        if (load_data !== 32'd0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_stale_resp: got ld=%h st=%b expected 0 0", load_data, stall);
        end
        exp_ld = '0;
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        // timeout while waiting for the response
        mem_read = 1; mem_write = 0; funct3 = 3'b010; addr = 32'h0000_4000;
        @(posedge clk); #1;
        checks++;
        if (req_valid_t !== 1'b1) begin
            errors++;
            $display("FAIL tmo_req: got v=%b expected 1", req_valid_t);
        end
        req_ready_t = 1;
        @(posedge clk); #1;
        req_ready_t = 0;
        n = 0;
        while (bus_err_t !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL tmo_wait_latency: got %0d cycles expected 4", n);
        end
        checks++;
        if (stall_t !== 1'b0 || req_valid_t !== 1'b0 || load_data_t !== 32'd0) begin
            errors++;
            $display("FAIL tmo_done: got st=%b v=%b ld=%h expected 0 0 0", stall_t, req_valid_t, load_data_t);
        end
        mem_read = 0;
        @(posedge clk); #1;
        checks++;
        if (bus_err_t !== 1'b0 || stall_t !== 1'b0) begin
            errors++;
            $display("FAIL tmo_pulse: got berr=%b st=%b expected 0 0", bus_err_t, stall_t);
        end
        // timeout while waiting for req_ready
        mem_read = 1;
        @(posedge clk); #1;
        n = 0;
        while (bus_err_t !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n !== 4 || req_valid_t !== 1'b0) begin
            errors++;
            $display("FAIL tmo_req_latency: got %0d cycles v=%b expected 4 0", n, req_valid_t);
        end
        mem_read = 0;
        do_reset();
    endtask

    initial begin
        test_reset();
        test_store_byte();
        test_load_extend();
        test_misaligned();
        test_ready_hold();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
